// File: rtl/packet_receiver.sv
// Sync-hunting 16-byte packet receiver with a double-buffered packet store and an idle timeout.
// Optional trailing XOR checksum byte: define RX_CHECKSUM_EN to enable it.
module packet_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic [3:0] read_index,
  output logic [7:0] read_data,
  output logic       packet_new,
  output logic       packet_valid,
  output logic [7:0] err_count
);

  localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef RX_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [3:0]              wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]        idle_q, idle_d;
  logic                    commit_q, commit_d;
  logic                    pkt_new_q, pkt_new_d;
  logic                    pkt_valid_q, pkt_valid_d;
  logic [7:0]              err_q, err_d;
  logic [1:0][15:0][7:0]   bank_q, bank_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif
  logic                    fill_sel;
  logic                    idle_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fill_sel     = ~commit_q;
  assign idle_hit     = (idle_q == IDLE_LAST);
  assign read_data    = bank_q[commit_q][read_index];
  assign packet_new   = pkt_new_q;
  assign packet_valid = pkt_valid_q;
  assign err_count    = err_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    idle_d      = idle_q;
    commit_d    = commit_q;
    pkt_new_d   = 1'b0;
    pkt_valid_d = pkt_valid_q;
    err_d       = err_q;
    bank_d      = bank_q;
`ifdef RX_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      HUNT: begin
        idle_d = '0;
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d  = PAYLOAD;
          wr_idx_d = '0;
`ifdef RX_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          // A sync-valued byte here is payload, not a frame restart.
          idle_d                      = '0;
          bank_d[fill_sel][wr_idx_q]  = rx_byte;
          wr_idx_d                    = wr_idx_q + 4'd1;
`ifdef RX_CHECKSUM_EN
          csum_d                      = csum_q ^ rx_byte;
          if (wr_idx_q == 4'hF) state_d = CHECK;
`else
          if (wr_idx_q == 4'hF) begin
            state_d     = HUNT;
            commit_d    = ~commit_q;
            pkt_new_d   = 1'b1;
            pkt_valid_d = 1'b1;
          end
`endif
        end else if (idle_hit) begin
          state_d = HUNT;
          idle_d  = '0;
          err_d   = sat_inc(err_q);
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
`ifdef RX_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          idle_d  = '0;
          state_d = HUNT;
          if (rx_byte == csum_q) begin
            commit_d    = ~commit_q;
            pkt_new_d   = 1'b1;
            pkt_valid_d = 1'b1;
          end else begin
            err_d = sat_inc(err_q);
          end
        end else if (idle_hit) begin
          state_d = HUNT;
          idle_d  = '0;
          err_d   = sat_inc(err_q);
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = HUNT;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      wr_idx_q    <= '0;
      idle_q      <= '0;
      commit_q    <= 1'b0;
      pkt_new_q   <= 1'b0;
      pkt_valid_q <= 1'b0;
      err_q       <= '0;
      bank_q      <= '0;
`ifdef RX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      idle_q      <= idle_d;
      commit_q    <= commit_d;
      pkt_new_q   <= pkt_new_d;
      pkt_valid_q <= pkt_valid_d;
      err_q       <= err_d;
      bank_q      <= bank_d;
`ifdef RX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule
